// File: rtl/voice_mixer.sv
// voice_mixer
//   Accumulates the per-voice subsamples of one frame from the operator core
//   into a single mono sample. The sum is scaled by an arithmetic right shift,
//   saturated to 16 bits and queued in a small FIFO for the DAC/serializer.
//   It also raises sticky flags for malformed frames and dropped samples.
//
// Ports
//   i_Clock          system clock
//   i_Reset_n        asynchronous active-low reset
//   i_Subsample      signed voice subsample from the core
//   i_SubsampleReady i_Subsample is valid this cycle
//   i_SampleReady    frame end (coincides with the frame's last subsample)
//   o_Sample         signed mixed sample at the FIFO head
//   o_Valid          FIFO non-empty
//   i_Ready          consumer accepts o_Sample
//   o_FrameError     sticky: a frame ended with a subsample count != VOICES
//   o_Overrun        sticky: a finished sample was dropped on a full FIFO
//   i_ClearFlags     synchronous clear of both sticky flags (a set wins)
module voice_mixer #(
    parameter int VOICES     = 16,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic signed [15:0] i_Subsample,
    input  logic               i_SubsampleReady,
    input  logic               i_SampleReady,
    output logic signed [15:0] o_Sample,
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic               o_FrameError,
    output logic               o_Overrun,
    input  logic               i_ClearFlags
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // SYNC discards everything up to the first frame end so that a partial
    // frame after reset never reaches the output.
    typedef enum logic {SYNC, RUN} state_t;

    state_t             state;
    logic signed [19:0] acc;
    logic signed [19:0] r_sum;
    logic [4:0]         cnt;
    logic               sum_valid;

    logic signed [19:0] sub_ext;
    logic signed [19:0] frame_sum;
    logic [4:0]         cnt_inc;
    logic               frame_bad;

    assign sub_ext   = {{4{i_Subsample[15]}}, i_Subsample};
    assign frame_sum = i_SubsampleReady ? acc + sub_ext : acc;
    assign cnt_inc   = (i_SubsampleReady && cnt != 5'd31) ? cnt + 5'd1 : cnt;
    // The count that matters includes the subsample arriving with the frame end.
    assign frame_bad = (state == RUN) && i_SampleReady && (cnt_inc != 5'(VOICES));

    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state     <= SYNC;
            acc       <= '0;
            cnt       <= '0;
            r_sum     <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            case (state)
                SYNC: begin
                    if (i_SampleReady) begin
                        state <= RUN;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (i_SampleReady) begin
                        r_sum     <= frame_sum;
                        sum_valid <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                    end else if (i_SubsampleReady) begin
                        acc <= frame_sum;
                        cnt <= cnt_inc;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    // Scale and saturate the captured frame sum.
    logic signed [19:0] shifted;
    logic signed [15:0] scaled;

    assign shifted = r_sum >>> SHIFT;

    always_comb begin
        if (shifted > 20'sd32767)
            scaled = 16'sh7fff;
        else if (shifted < -20'sd32768)
            scaled = 16'sh8000;
        else
            scaled = shifted[15:0];
    end

    // Output FIFO. Pointers carry one extra wrap bit so full and empty differ.
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next, occupancy;
    logic        full, pop, push_ok, overrun_set;
    logic [15:0] head_next;

    assign occupancy   = wr_ptr - rd_ptr;
    assign full        = (occupancy == (AW+1)'(FIFO_DEPTH));
    assign pop         = o_Valid && i_Ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok     = sum_valid && (!full || pop);
    assign overrun_set = sum_valid && full && !pop;

    // NOTE: every signal is given a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_next   = rd_ptr;
        wr_next   = wr_ptr;
        if (pop)
            rd_next = rd_ptr + PTR_ONE;
        if (push_ok)
            wr_next = wr_ptr + PTR_ONE;
        // o_Sample is registered, so precompute the next head: the word being
        // written when it lands in the head slot (FIFO drains to empty),
        // otherwise the stored word.
        head_next = mem[rd_next[AW-1:0]];
        if (push_ok && rd_next[AW-1:0] == wr_ptr[AW-1:0])
            head_next = scaled;
    end

    // NOTE: the storage array is reset because o_Sample must read 0 after
    // reset; without that requirement it could be left unreset.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_Valid  <= 1'b0;
            o_Sample <= '0;
        end else begin
            if (push_ok)
                mem[wr_ptr[AW-1:0]] <= scaled;
            wr_ptr   <= wr_next;
            rd_ptr   <= rd_next;
            o_Valid  <= (wr_next != rd_next);
            o_Sample <= head_next;
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_FrameError <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            o_FrameError <= frame_bad   || (o_FrameError && !i_ClearFlags);
            o_Overrun    <= overrun_set || (o_Overrun    && !i_ClearFlags);
        end
    end

endmodule
